// File: rtl/par2ser_stream_pkg.sv
// Shared definitions for the parallel-to-serial stream block: state encoding
// and default parameter values.
package par2ser_stream_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam bit          DEF_MSB_FIRST = 1'b1;
  localparam bit          DEF_IDLE_BIT  = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ser_hold_reg.sv
// One-word holding register with full flag; buffers the next word while the
// shifter is still sending the current one.
module ser_hold_reg
  import par2ser_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_take,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  logic [DATA_W-1:0] r_data;
  logic              r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/par2ser_stream.sv
// Parallel-to-serial streamer: valid/ready word input, registered serial bit
// output with valid and start-of-frame flags, back-to-back words without gaps.
module par2ser_stream
  import par2ser_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter bit          MSB_FIRST = DEF_MSB_FIRST,
  parameter bit          IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic              dclk,
  input  logic              default_values,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic              data_out,
  output logic              valid_out,
  output logic              sof_out,
  output logic              busy
);

  localparam int unsigned    CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_dout, w_dout_nxt;
  logic              r_vout, w_vout_nxt;
  logic              r_sof, w_sof_nxt;

  logic              w_hold_full, w_hold_load, w_hold_take;
  logic [DATA_W-1:0] w_hold_data;
  logic              w_xfer, w_last;

  // First bit and remaining bits for each possible shifter source
  logic              w_in_bit, w_hd_bit, w_sh_bit;
  logic [DATA_W-1:0] w_in_rest, w_hd_rest, w_sh_rest;

  assign w_in_bit  = MSB_FIRST ? data_in[DATA_W-1]     : data_in[0];
  assign w_hd_bit  = MSB_FIRST ? w_hold_data[DATA_W-1] : w_hold_data[0];
  assign w_sh_bit  = MSB_FIRST ? r_shift[DATA_W-1]     : r_shift[0];
  assign w_in_rest = MSB_FIRST ? (data_in << 1)     : (data_in >> 1);
  assign w_hd_rest = MSB_FIRST ? (w_hold_data << 1) : (w_hold_data >> 1);
  assign w_sh_rest = MSB_FIRST ? (r_shift << 1)     : (r_shift >> 1);

  assign ready_in = ~w_hold_full;
  assign w_xfer   = valid_in & ready_in;
  assign w_last   = (r_cnt == CNT_LAST);
  assign busy     = (r_state == ST_SHIFT) | w_hold_full;

  ser_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk    (dclk),
    .rst    (default_values),
    .i_load (w_hold_load),
    .i_take (w_hold_take),
    .i_data (data_in),
    .o_data (w_hold_data),
    .o_full (w_hold_full)
  );

  always_ff @(posedge dclk or posedge default_values) begin
    if (default_values) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_ff @(posedge dclk or posedge default_values) begin
    if (default_values) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_dout  <= IDLE_BIT;
      r_vout  <= 1'b0;
      r_sof   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_dout  <= w_dout_nxt;
      r_vout  <= w_vout_nxt;
      r_sof   <= w_sof_nxt;
    end
  end

  // Next state; the last-bit edge reloads from the hold register or input
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_dout_nxt  = IDLE_BIT;
    w_vout_nxt  = 1'b0;
    w_sof_nxt   = 1'b0;
    w_hold_load = 1'b0;
    w_hold_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_nxt = w_in_rest;
          w_dout_nxt  = w_in_bit;
          w_vout_nxt  = 1'b1;
          w_sof_nxt   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!w_last) begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_shift_nxt = w_sh_rest;
          w_dout_nxt  = w_sh_bit;
          w_vout_nxt  = 1'b1;
          w_hold_load = w_xfer;
        end else if (w_hold_full) begin
          w_hold_take = 1'b1;
          w_cnt_nxt   = '0;
          w_shift_nxt = w_hd_rest;
          w_dout_nxt  = w_hd_bit;
          w_vout_nxt  = 1'b1;
          w_sof_nxt   = 1'b1;
        end else if (w_xfer) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = w_in_rest;
          w_dout_nxt  = w_in_bit;
          w_vout_nxt  = 1'b1;
          w_sof_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign data_out  = r_dout;
  assign valid_out = r_vout;
  assign sof_out   = r_sof;

endmodule

// File: tb/tb_par2ser_stream.sv
// Randomised bench for par2ser_stream: three parameterisations share one
// stimulus stream and are checked against a word-queue reference model.
module tb_par2ser_stream;

  localparam int N = 3;

  logic       dclk = 1'b0;
  logic       default_values;
  logic       vin;
  logic [7:0] din;
  logic       rdy[N], dout[N], vout[N], sof[N], bsy[N];

  int n_chk = 0;
  int n_err = 0;

  // Model: up to two accepted words per instance, front word is on the wire
  int         m_n[N];
  int         m_pos[N];
  logic [7:0] m_w[N][2];

  always #5 dclk = ~dclk;

  par2ser_stream #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut0 (
    .dclk(dclk), .default_values(default_values), .data_in(din), .valid_in(vin),
    .ready_in(rdy[0]), .data_out(dout[0]), .valid_out(vout[0]), .sof_out(sof[0]),
    .busy(bsy[0]));

  par2ser_stream #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut1 (
    .dclk(dclk), .default_values(default_values), .data_in(din), .valid_in(vin),
    .ready_in(rdy[1]), .data_out(dout[1]), .valid_out(vout[1]), .sof_out(sof[1]),
    .busy(bsy[1]));

  par2ser_stream #(.DATA_W(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut2 (
    .dclk(dclk), .default_values(default_values), .data_in(din[4:0]), .valid_in(vin),
    .ready_in(rdy[2]), .data_out(dout[2]), .valid_out(vout[2]), .sof_out(sof[2]),
    .busy(bsy[2]));

  function automatic int wid(input int k);
    return (k == 2) ? 5 : 8;
  endfunction

  function automatic bit msb(input int k);
    return (k != 1);
  endfunction

  function automatic bit idl(input int k);
    return (k == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_n[k]   = 0;
      m_pos[k] = 0;
      m_w[k][0] = '0;
      m_w[k][1] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      bit was;
      was = (m_n[k] > 0);
      if (vin && m_n[k] < 2) begin
        m_w[k][m_n[k]] = din;
        m_n[k]++;
      end
      if (was) begin
        m_pos[k]++;
        if (m_pos[k] == wid(k)) begin
          m_w[k][0] = m_w[k][1];
          m_n[k]--;
          m_pos[k] = 0;
        end
      end
    end
  endtask

  task automatic check_out(input string ph);
    for (int k = 0; k < N; k++) begin
      logic e_v, e_d;
      int   idx;
      e_v = (m_n[k] > 0);
      idx = msb(k) ? (wid(k) - 1 - m_pos[k]) : m_pos[k];
      e_d = e_v ? m_w[k][0][idx] : idl(k);
      chk($sformatf("%s/u%0d/valid_out", ph, k), 32'(vout[k]), 32'(e_v));
      chk($sformatf("%s/u%0d/data_out", ph, k), 32'(dout[k]), 32'(e_d));
      chk($sformatf("%s/u%0d/sof_out", ph, k), 32'(sof[k]), 32'(e_v && m_pos[k] == 0));
      chk($sformatf("%s/u%0d/busy", ph, k), 32'(bsy[k]), 32'(e_v));
      chk($sformatf("%s/u%0d/ready_in", ph, k), 32'(rdy[k]), 32'(m_n[k] < 2));
    end
  endtask

  task automatic cycle(input string ph, input logic v, input logic [7:0] d);
    @(negedge dclk);
    vin = v;
    din = d;
    for (int k = 0; k < N; k++)
      chk($sformatf("%s/u%0d/ready_pre", ph, k), 32'(rdy[k]), 32'(m_n[k] < 2));
    @(posedge dclk);
    model_edge();
    #1;
    check_out(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph, 1'b0, 8'($urandom));
  endtask

  initial begin
    default_values = 1'b1;
    vin = 1'b0;
    din = '0;
    model_clear();
    repeat (2) @(posedge dclk);
    #1;
    check_out("reset");
    @(negedge dclk);
    default_values = 1'b0;

    cycle("a5", 1'b1, 8'hA5);
    idle("a5", 10);
    cycle("w01", 1'b1, 8'h01);
    idle("w01", 9);
    cycle("w13", 1'b1, 8'h13);
    idle("w13", 9);

    cycle("b2b", 1'b1, 8'hF0);
    cycle("b2b", 1'b1, 8'h0F);
    idle("b2b", 18);

    cycle("last", 1'b1, 8'h96);
    idle("last", 7);
    cycle("last", 1'b1, 8'h69);
    idle("last", 10);

    // Reset in the middle of a word with a second word held
    cycle("arst", 1'b1, 8'hFF);
    cycle("arst", 1'b1, 8'h33);
    idle("arst", 3);
    #2;
    default_values = 1'b1;
    model_clear();
    #1;
    check_out("arst_async");
    @(negedge dclk);
    default_values = 1'b0;
    vin = 1'b1;
    din = 8'h3C;
    @(posedge dclk);
    model_edge();
    #1;
    check_out("first_xfer");
    idle("first_xfer", 12);

    for (int i = 0; i < 500; i++)
      cycle("rand", ($urandom_range(0, 3) != 0), 8'($urandom));
    idle("drain", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
